// File: rtl/edge_detect_pkg.sv
// Purpose: shared constants and sizing helpers for the multi-channel edge detector.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package edge_detect_pkg;

  // Defaults used by the top and channel modules.
  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILTER_LEN  = 3;
  localparam bit DEF_RESET_LEVEL = 1'b0;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of the filter counter. The counter only needs to reach
  // FILTER_LEN-1, and it is kept at least 1 bit wide so that
  // FILTER_LEN=1 still yields a legal vector.
  function automatic int filter_cnt_w(input int filter_len);
    int w;
    w = clog2(filter_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_detect_multi_if.sv
// Purpose: bundle of raw inputs, clears and detector outputs for all channels.
// Latency: n/a (wires only).
// Backpressure: none; all outputs are free-running strobes and levels.
// Ports (via modports):
//   master: drives s/clr, observes level/pos/neg/evt_pos/evt_neg/any_pos/any_neg
//   slave : the detector side, the reverse directions
interface edge_detect_multi_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] pos;
  logic [CHANNELS-1:0] neg;
  logic [CHANNELS-1:0] evt_pos;
  logic [CHANNELS-1:0] evt_neg;
  logic                any_pos;
  logic                any_neg;

  modport master (
    output s, clr,
    input  level, pos, neg, evt_pos, evt_neg, any_pos, any_neg
  );

  modport slave (
    input  s, clr,
    output level, pos, neg, evt_pos, evt_neg, any_pos, any_neg
  );

endinterface

// File: rtl/edge_detect_channel.sv
// Purpose: one channel -- synchroniser chain, glitch filter, edge pulses, sticky flags.
// Latency: input change first sampled at edge E reaches level/pos/neg at E+SYNC_STAGES+FILTER_LEN-1.
// Backpressure: none; pulses are one cycle wide and never stall.
// Ports: clk, reset (sync, active low), s (raw async in), clr (sticky clear),
//        level (filtered level), pos/neg (edge pulses), evt_pos/evt_neg (sticky flags)
module edge_detect_channel
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter bit RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic clr,
  output logic level,
  output logic pos,
  output logic neg,
  output logic evt_pos,
  output logic evt_neg
);

  localparam int                 CNT_W   = filter_cnt_w(FILTER_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_out;
  logic                   accept;
  logic                   pos_next;
  logic                   neg_next;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A new level is accepted once it has differed from the current level for
  // FILTER_LEN consecutive evaluations; the counter restarts whenever the
  // synchronised input falls back, so short excursions never get through.
  assign accept   = (sync_out != level) && (cnt_q == CNT_MAX);
  assign pos_next = accept &  sync_out;
  assign neg_next = accept & ~sync_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      level   <= RESET_LEVEL;
      cnt_q   <= '0;
      pos     <= 1'b0;
      neg     <= 1'b0;
      evt_pos <= 1'b0;
      evt_neg <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], s};

      if (sync_out == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level <= sync_out;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      pos <= pos_next;
      neg <= neg_next;

      // Set has priority over clear so an edge landing in the clear cycle is kept.
      evt_pos <= pos_next | (evt_pos & ~clr);
      evt_neg <= neg_next | (evt_neg & ~clr);
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// Purpose: CHANNELS independent edge detectors plus any-edge summary strobes.
// Latency: SYNC_STAGES+FILTER_LEN-1 edges from first sample to pulse; any_pos/any_neg add none.
// Backpressure: none.
// Ports: clk, reset (sync, active low), bus (edge_detect_multi_if.slave:
//        s, clr in; level, pos, neg, evt_pos, evt_neg, any_pos, any_neg out)
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter bit RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic                clk,
  input  logic                reset,
  edge_detect_multi_if.slave  bus
);

  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] pos_w;
  logic [CHANNELS-1:0] neg_w;
  logic [CHANNELS-1:0] evt_pos_w;
  logic [CHANNELS-1:0] evt_neg_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_detect_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .s       (bus.s[i]),
      .clr     (bus.clr[i]),
      .level   (level_w[i]),
      .pos     (pos_w[i]),
      .neg     (neg_w[i]),
      .evt_pos (evt_pos_w[i]),
      .evt_neg (evt_neg_w[i])
    );
  end

  assign bus.level   = level_w;
  assign bus.pos     = pos_w;
  assign bus.neg     = neg_w;
  assign bus.evt_pos = evt_pos_w;
  assign bus.evt_neg = evt_neg_w;

  // Straight ORs of the registered pulses, so they line up with pos/neg.
  assign bus.any_pos = |pos_w;
  assign bus.any_neg = |neg_w;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Purpose: directed self-checking bench for edge_detect_multi (4 ch, 2 sync, filter 3).
// Latency: checks sample 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_edge_detect_multi;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  edge_detect_multi_if #(.CHANNELS(4)) bus ();

  edge_detect_multi #(
    .CHANNELS    (4),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3),
    .RESET_LEVEL (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    assert (obs === exp_v) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   32'(bus.level),   32'h0);
    chk({tag, "_pos"},     32'(bus.pos),     32'h0);
    chk({tag, "_neg"},     32'(bus.neg),     32'h0);
    chk({tag, "_evt_pos"}, 32'(bus.evt_pos), 32'h0);
    chk({tag, "_evt_neg"}, 32'(bus.evt_neg), 32'h0);
    chk({tag, "_any_pos"}, 32'(bus.any_pos), 32'h0);
    chk({tag, "_any_neg"}, 32'(bus.any_neg), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_pos;
    logic [3:0] exp_neg;
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b0;
    bus.s   = 4'b0000;
    bus.clr = 4'b0000;

    // Reset state.
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b1;
    step();
    chk("post_release_pos", 32'(bus.pos), 32'h0);

    // Single rising input on channel 0: pulse at edge 4 only.
    bus.s = 4'b0001;
    for (int e = 0; e <= 6; e++) begin
      step();
      chk($sformatf("rise0_pos_e%0d", e),     32'(bus.pos),     (e == 4) ? 32'h1 : 32'h0);
      chk($sformatf("rise0_any_pos_e%0d", e), 32'(bus.any_pos), (e == 4) ? 32'h1 : 32'h0);
      chk($sformatf("rise0_level_e%0d", e),   32'(bus.level),   (e >= 4) ? 32'h1 : 32'h0);
    end
    chk("rise0_evt_pos", 32'(bus.evt_pos), 32'h1);

    // Two-cycle glitch on channel 1 is rejected.
    bus.s = 4'b0011;
    step();
    step();
    bus.s = 4'b0001;
    for (int e = 2; e <= 9; e++) begin
      step();
      chk($sformatf("glitch1_pos_e%0d", e), 32'(bus.pos), 32'h0);
    end
    chk("glitch1_level",   32'(bus.level),   32'h1);
    chk("glitch1_evt_pos", 32'(bus.evt_pos), 32'h1);

    // Channel 2 rises, then falls: neg pulse 4 edges after first falling sample.
    bus.s = 4'b0101;
    for (int e = 0; e <= 5; e++) step();
    chk("rise2_level",   32'(bus.level),   32'h5);
    chk("rise2_evt_pos", 32'(bus.evt_pos), 32'h5);
    bus.s = 4'b0001;
    for (int e = 0; e <= 6; e++) begin
      step();
      chk($sformatf("fall2_neg_e%0d", e),     32'(bus.neg),     (e == 4) ? 32'h4 : 32'h0);
      chk($sformatf("fall2_any_neg_e%0d", e), 32'(bus.any_neg), (e == 4) ? 32'h1 : 32'h0);
    end
    chk("fall2_evt_neg", 32'(bus.evt_neg), 32'h4);
    chk("fall2_level",   32'(bus.level),   32'h1);

    // Sticky flag: set and clear in the same cycle, set wins; clear alone clears.
    bus.s = 4'b0000;
    for (int e = 0; e <= 5; e++) step();
    chk("fall0_level",   32'(bus.level),   32'h0);
    chk("fall0_evt_neg", 32'(bus.evt_neg), 32'h5);
    bus.s = 4'b0001;
    for (int e = 0; e <= 3; e++) step();
    bus.clr = 4'b0001;
    step();
    chk("setclr_pos",     32'(bus.pos),     32'h1);
    chk("setclr_evt_pos", 32'(bus.evt_pos), 32'h5);
    step();
    chk("clr_evt_pos", 32'(bus.evt_pos), 32'h4);
    chk("clr_evt_neg", 32'(bus.evt_neg), 32'h4);
    chk("clr_level",   32'(bus.level),   32'h1);
    bus.clr = 4'b0000;

    // Mid-operation reset aborts filtering; pulse 4 edges after release.
    bus.s = 4'b1111;
    for (int e = 0; e <= 2; e++) begin
      step();
      chk($sformatf("prerst_pos_e%0d", e), 32'(bus.pos), 32'h0);
    end
    reset = 1'b0;
    step();
    chk_all_zero("midrst");
    reset = 1'b1;
    for (int e = 4; e <= 9; e++) begin
      step();
      chk($sformatf("postrst_pos_e%0d", e),   32'(bus.pos),   (e == 8) ? 32'hF : 32'h0);
      chk($sformatf("postrst_level_e%0d", e), 32'(bus.level), (e >= 8) ? 32'hF : 32'h0);
    end

    // Channel 3 toggled every 4 cycles: alternating pulses, never both.
    for (int e = 0; e <= 43; e++) begin
      if ((e % 4 == 0) && (e / 4 <= 9)) begin
        bus.s[3] = ((e / 4) % 2 == 1);
      end
      step();
      exp_pos = 4'b0000;
      exp_neg = 4'b0000;
      if ((e >= 4) && (e % 4 == 0) && (e / 4 - 1 <= 9)) begin
        if (((e / 4 - 1) % 2) == 0) exp_neg = 4'b1000;
        else                        exp_pos = 4'b1000;
      end
      chk($sformatf("tog3_pos_e%0d", e), 32'(bus.pos), 32'(exp_pos));
      chk($sformatf("tog3_neg_e%0d", e), 32'(bus.neg), 32'(exp_neg));
      chk($sformatf("tog3_excl_e%0d", e), 32'(bus.pos & bus.neg), 32'h0);
    end
    chk("tog3_level", 32'(bus.level), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
